// File: rtl/fpu_pkg.sv
// fpu_pkg: FP op encodings, sequencer state type and fflags bit positions shared by the FPU issue logic.
package fpu_pkg;
  localparam logic [4:0] FADD      = 5'b00000;
  localparam logic [4:0] FSUB      = 5'b00001;
  localparam logic [4:0] FMUL      = 5'b00010;
  localparam logic [4:0] FDIV      = 5'b00011;
  localparam logic [4:0] FSQRT     = 5'b00100;
  localparam logic [4:0] FSGNJ     = 5'b00101;
  localparam logic [4:0] FSGNJN    = 5'b00110;
  localparam logic [4:0] FSGNJX    = 5'b00111;
  localparam logic [4:0] FMIN      = 5'b01000;
  localparam logic [4:0] FMAX      = 5'b01001;
  localparam logic [4:0] FCVT_W_S  = 5'b01010;
  localparam logic [4:0] FCVT_WU_S = 5'b01011;
  localparam logic [4:0] FEQ       = 5'b01100;
  localparam logic [4:0] FLT       = 5'b01101;
  localparam logic [4:0] FLE       = 5'b01110;
  localparam logic [4:0] FMV_W_X   = 5'b01111;
  localparam logic [4:0] FMADD     = 5'b10000;
  localparam logic [4:0] FMSUB     = 5'b10001;
  localparam logic [4:0] FNMSUB    = 5'b10010;
  localparam logic [4:0] FNMADD    = 5'b10011;
  localparam logic [4:0] FCLASS    = 5'b10100;
  localparam logic [4:0] FMV_X_W   = 5'b10101;
  localparam logic [4:0] FCVT_S_W  = 5'b10110;
  localparam logic [4:0] FCVT_S_WU = 5'b10111;
  localparam logic [4:0] FNOP      = 5'b11111;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  typedef enum logic [1:0] {IDLE, COUNT, WAIT_DONE, WB} seq_state_e;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = c > m ? c : m;
    return d > m ? d : m;
  endfunction
endpackage

// File: rtl/fpu_lat_lut.sv
// fpu_lat_lut: maps an fpusel code to its issue class (iterative or fixed) and fixed latency.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_FMA  = 5,
  parameter int LAT_MISC = 1,
  parameter int CW       = 4
) (
  input  logic [4:0]    fpusel,
  output logic          is_iter,
  output logic [CW-1:0] lat
);
  always_comb begin
    is_iter = fpusel == FDIV || fpusel == FSQRT;
    lat = fpusel inside {FADD, FSUB, FCVT_W_S, FCVT_WU_S, FCVT_S_W, FCVT_S_WU} ? CW'(LAT_ADD)
        : fpusel == FMUL                                   ? CW'(LAT_MUL)
        : fpusel inside {FMADD, FMSUB, FNMSUB, FNMADD}     ? CW'(LAT_FMA)
        :                                                    CW'(LAT_MISC);
  end
endmodule

// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: issues one FP op at a time to the shared FPU, tracks its latency and returns one writeback beat.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int LAT_ADD      = 3,
  parameter int LAT_MUL      = 4,
  parameter int LAT_FMA      = 5,
  parameter int LAT_MISC     = 1,
  parameter int ITER_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  fpusel,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        unit_start,
  output logic [4:0]  unit_op,
  output logic        unit_abort,
  input  logic        unit_done,
  input  logic [31:0] result_in,
  input  logic [4:0]  fflags_in,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_flags,
  output logic        wb_timeout
);
  localparam int CW = $clog2(max4(LAT_ADD, LAT_MUL, LAT_FMA, LAT_MISC)) + 1;
  localparam int IW = $clog2(ITER_TIMEOUT) + 1;
  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat;
  logic [IW-1:0] iter;
  logic          is_iter;
  logic          accept;
  fpu_lat_lut #(
    .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_FMA(LAT_FMA), .LAT_MISC(LAT_MISC), .CW(CW)
  ) u_lut (
    .fpusel(fpusel),
    .is_iter(is_iter),
    .lat(lat)
  );
  always_comb begin
    issue_ready = state == IDLE;
    stall       = state != IDLE;
    accept      = issue_valid && issue_ready && !flush && fpusel != FNOP;
    wb_valid    = state == WB && !flush;
  end
  // wb_timeout is rewritten every cycle so it is only ever high alongside the WB beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      unit_start <= 1'b0;
      unit_abort <= 1'b0;
      wb_timeout <= 1'b0;
      wb_data    <= '0;
      wb_flags   <= '0;
      wb_rd      <= '0;
      unit_op    <= FNOP;
      cnt        <= '0;
      iter       <= '0;
    end else begin
      unit_start <= 1'b0;
      unit_abort <= 1'b0;
      wb_timeout <= 1'b0;
      if (flush) begin
        unit_abort <= state == COUNT || state == WAIT_DONE;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            unit_op    <= fpusel;
            wb_rd      <= rd;
            unit_start <= 1'b1;
            cnt        <= lat;
            iter       <= '0;
            state      <= is_iter ? WAIT_DONE : COUNT;
          end
          COUNT: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              wb_data  <= result_in;
              wb_flags <= fflags_in;
              state    <= WB;
            end
          end
          WAIT_DONE: begin
            iter <= iter + IW'(iter != {IW{1'b1}});
            if (unit_done) begin
              wb_data  <= result_in;
              wb_flags <= fflags_in;
              state    <= WB;
            end else if (iter == IW'(ITER_TIMEOUT)) begin
              wb_data    <= '0;
              wb_flags   <= 5'b00001 << FF_NV;
              wb_timeout <= 1'b1;
              state      <= WB;
            end
          end
          WB: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_seq.sv
// tb_fpu_issue_seq: directed checks of fpu_issue_seq timing, timeout, flush and reset behaviour.
module tb_fpu_issue_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  fpusel = 5'b11111;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        unit_start;
  logic [4:0]  unit_op;
  logic        unit_abort;
  logic        unit_done = 1'b0;
  logic [31:0] result_in = '0;
  logic [4:0]  fflags_in = '0;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_flags;
  logic        wb_timeout;
  int          n_chk = 0;
  int          n_fail = 0;
  fpu_issue_seq dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .fpusel(fpusel), .rd(rd), .flush(flush), .unit_start(unit_start), .unit_op(unit_op),
    .unit_abort(unit_abort), .unit_done(unit_done), .result_in(result_in), .fflags_in(fflags_in),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
    .wb_timeout(wb_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic accept_op(input logic [4:0] op, input logic [4:0] dst);
    issue_valid = 1'b1;
    fpusel = op;
    rd = dst;
    tick();
    issue_valid = 1'b0;
    fpusel = 5'b11111;
  endtask
  task automatic cycles_to_wb(input string tag, input int exp);
    int n;
    n = 1;
    while (!wb_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 32'(issue_ready), 1);
    check("rst_stall", 32'(stall), 0);
    check("rst_start", 32'(unit_start), 0);
    check("rst_abort", 32'(unit_abort), 0);
    check("rst_wbv", 32'(wb_valid), 0);
    check("rst_wbto", 32'(wb_timeout), 0);
    check("rst_op", 32'(unit_op), 32'h1f);
    check("rst_data", wb_data, 0);
    check("rst_flags", 32'(wb_flags), 0);
    check("rst_rd", 32'(wb_rd), 0);
    // fadd accepted at edge 0
    accept_op(5'b00000, 5'd5);
    check("add_start1", 32'(unit_start), 1);
    check("add_stall1", 32'(stall), 1);
    check("add_op1", 32'(unit_op), 0);
    check("add_ready1", 32'(issue_ready), 0);
    result_in = 32'h11111111;
    tick();
    check("add_start2", 32'(unit_start), 0);
    check("add_wbv2", 32'(wb_valid), 0);
    result_in = 32'h22222222;
    tick();
    check("add_wbv3", 32'(wb_valid), 0);
    result_in = 32'h3f800001;
    fflags_in = 5'b00001;
    tick();
    result_in = 32'h0;
    fflags_in = 5'b0;
    check("add_wbv4", 32'(wb_valid), 1);
    check("add_data4", wb_data, 32'h3f800001);
    check("add_flags4", 32'(wb_flags), 1);
    check("add_rd4", 32'(wb_rd), 5);
    check("add_stall4", 32'(stall), 1);
    check("add_to4", 32'(wb_timeout), 0);
    tick();
    check("add_wbv5", 32'(wb_valid), 0);
    check("add_stall5", 32'(stall), 0);
    // fdiv with done at cycle 10
    accept_op(5'b00011, 5'd7);
    check("div_start1", 32'(unit_start), 1);
    for (int i = 1; i < 10; i++) tick();
    check("div_wbv10", 32'(wb_valid), 0);
    check("div_stall10", 32'(stall), 1);
    unit_done = 1'b1;
    result_in = 32'h3f800000;
    tick();
    unit_done = 1'b0;
    result_in = 32'h0;
    check("div_wbv11", 32'(wb_valid), 1);
    check("div_data11", wb_data, 32'h3f800000);
    check("div_to11", 32'(wb_timeout), 0);
    check("div_rd11", 32'(wb_rd), 7);
    tick();
    // fsqrt timeout: counter hits 64 in cycle 65, beat in cycle 66
    result_in = 32'hdeadbeef;
    accept_op(5'b00100, 5'd2);
    cycles_to_wb("sqrt_to_cycle", 66);
    check("sqrt_to", 32'(wb_timeout), 1);
    check("sqrt_flags", 32'(wb_flags), 32'h10);
    check("sqrt_data", wb_data, 0);
    tick();
    // done in the timeout cycle wins
    accept_op(5'b00011, 5'd8);
    for (int i = 1; i < 65; i++) tick();
    check("div_edge_wbv65", 32'(wb_valid), 0);
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("div_edge_wbv66", 32'(wb_valid), 1);
    check("div_edge_to", 32'(wb_timeout), 0);
    check("div_edge_data", wb_data, 32'hdeadbeef);
    result_in = 32'h0;
    tick();
    // fixed latencies per class
    accept_op(5'b00010, 5'd1);
    cycles_to_wb("mul_cycle", 5);
    tick();
    accept_op(5'b10000, 5'd1);
    cycles_to_wb("fma_cycle", 6);
    tick();
    accept_op(5'b10110, 5'd1);
    cycles_to_wb("cvt_cycle", 4);
    tick();
    accept_op(5'b11000, 5'd1);
    cycles_to_wb("undef_cycle", 2);
    tick();
    // fmul flushed at cycle 2, fadd accepted at cycle 3
    accept_op(5'b00010, 5'd9);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_abort3", 32'(unit_abort), 1);
    check("fl_stall3", 32'(stall), 0);
    check("fl_ready3", 32'(issue_ready), 1);
    check("fl_wbv3", 32'(wb_valid), 0);
    accept_op(5'b00000, 5'd3);
    check("fl_start4", 32'(unit_start), 1);
    check("fl_abort4", 32'(unit_abort), 0);
    tick();
    check("fl_wbv5", 32'(wb_valid), 0);
    tick();
    check("fl_wbv6", 32'(wb_valid), 0);
    tick();
    check("fl_wbv7", 32'(wb_valid), 1);
    check("fl_rd7", 32'(wb_rd), 3);
    tick();
    // flush during WB suppresses the beat without abort
    accept_op(5'b00101, 5'd4);
    tick();
    check("flwb_wbv", 32'(wb_valid), 1);
    flush = 1'b1;
    #1;
    check("flwb_wbv_fl", 32'(wb_valid), 0);
    tick();
    flush = 1'b0;
    check("flwb_abort", 32'(unit_abort), 0);
    check("flwb_stall", 32'(stall), 0);
    // FNOP ignored
    issue_valid = 1'b1;
    fpusel = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nop_ready", 32'(issue_ready), 1);
      check("nop_start", 32'(unit_start), 0);
      check("nop_wbv", 32'(wb_valid), 0);
    end
    // flush with issue in IDLE blocks accept
    fpusel = 5'b00000;
    flush = 1'b1;
    tick();
    issue_valid = 1'b0;
    flush = 1'b0;
    check("flidle_start", 32'(unit_start), 0);
    check("flidle_stall", 32'(stall), 0);
    // reset during WAIT_DONE
    accept_op(5'b00011, 5'd6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_stall", 32'(stall), 0);
    check("rmid_op", 32'(unit_op), 32'h1f);
    check("rmid_rd", 32'(wb_rd), 0);
    check("rmid_data", wb_data, 0);
    check("rmid_abort", 32'(unit_abort), 0);
    check("rmid_wbv", 32'(wb_valid), 0);
    unit_done = 1'b1;
    result_in = 32'h12345678;
    tick();
    unit_done = 1'b0;
    check("rmid_late_wbv", 32'(wb_valid), 0);
    check("rmid_late_stall", 32'(stall), 0);
    check("rmid_late_data", wb_data, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
